// File: rtl/ibus_responder.sv
// ibus_responder: instruction-bus slave that answers a held fetch request after LATENCY cycles from a preloadable word array
module ibus_responder #(
  parameter logic [63:0] BASE = 64'h8000_0000,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [63:0]   req_addr,
  output logic          resp_addr_ok,
  output logic          resp_data_ok,
  output logic [31:0]   resp_data,
  output logic          resp_err,
  input  logic          stall,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  output logic          proto_err,
  output logic [31:0]   resp_count
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [31:0] mem [DEPTH];
  logic [3:0] cnt, cnt_nxt;
  logic [63:0] addr_q, src, off;
  logic err, err_q, go;
  always_comb begin
    src = state == IDLE ? req_addr : addr_q;
    off = src - BASE;
    err = (|src[1:0]) || (off >= 64'(4 * DEPTH));
    go = req_valid && (state == IDLE ? LATENCY == 1 : state == WAIT && !stall && cnt <= 4'd1);
    nxt = go ? RESP : (state != RESP && req_valid) ? WAIT : IDLE;
    cnt_nxt = state == IDLE ? 4'(LATENCY - 1) : (state == WAIT && !stall && cnt > 4'd1) ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      err_q <= 1'b0;
      resp_data <= '0;
      proto_err <= 1'b0;
      resp_count <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      if (state == IDLE) addr_q <= req_addr;
      if (go) begin
        err_q <= err;
        resp_data <= err ? 32'd0 : mem[off[AW+1:2]];
      end
      if (state == WAIT && req_valid && req_addr != addr_q) proto_err <= 1'b1;
      if (state == RESP) resp_count <= resp_count + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end
  assign resp_addr_ok = state == RESP;
  assign resp_data_ok = state == RESP;
  assign resp_err = state == RESP && err_q;
endmodule

// File: doc/ibus_responder.md
Name: ibus_responder

Overview:
- Slave/responder end of the instruction-bus request/response handshake; the fetch stage's program counter is the initiator.
- Accepts a held request (valid + addr), waits a programmable number of cycles, then returns one 32-bit instruction word with addr_ok and data_ok asserted together for one cycle.
- Backed by a word-addressed instruction array with a preload write port.
- Used as the fetch-side memory model in simulation and as the reference slave for fetch verification.

Parameters:
- BASE, 64'h8000_0000, byte address mapped to array index 0; matches PCINIT.
- DEPTH, 1024, number of 32-bit words in the array.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  initiator request valid; held until the response is seen
- req_addr  in  64  instruction byte address
- resp_addr_ok  out  1  address accepted; pulses together with resp_data_ok
- resp_data_ok  out  1  data valid this cycle
- resp_data  out  32  instruction word
- resp_err  out  1  with the response: address misaligned or outside the array
- stall  in  1  freezes the latency counter; models bus contention
- wr_en  in  1  preload write enable
- wr_idx  in  $clog2(DEPTH)  preload word index
- wr_data  in  32  preload data
- proto_err  out  1  sticky: req_addr changed while a request was in flight
- resp_count  out  32  completed responses; wraps at 2^32

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset: state=IDLE; resp_addr_ok, resp_data_ok, resp_err and proto_err = 0; resp_data = 0; cnt = 0; resp_count = 0. Array contents are not reset.
- Reset mid-operation: any in-flight request is dropped and no response is issued.
- IDLE:
  - If req_valid=1 at an edge, latch addr_q=req_addr and cnt=LATENCY-1, then go to WAIT.
  - If LATENCY=1, go straight to RESP at that edge instead.
- WAIT:
  - If req_valid=0, abort to IDLE with no response.
  - Else if stall=1, hold cnt.
  - Else if cnt>1, decrement cnt.
  - Else (cnt<=1), go to RESP.
  - Latency rule: with no stall, the response is high in cycle LATENCY, counting the cycle where req_valid is first seen in IDLE as cycle 0. Each stall cycle adds exactly 1.
- Entering RESP (registered at the same edge):
  - off = addr_q - BASE, 64-bit unsigned; a wrap below BASE is out of range.
  - err = (addr_q[1:0] != 0) | (off[63:2] >= DEPTH).
  - resp_data = err ? 0 : mem[off[2+:$clog2(DEPTH)]].
  - resp_err = err.
- RESP:
  - resp_addr_ok = resp_data_ok = 1 for exactly one cycle.
  - resp_count increments at the exit edge.
  - Next state is always IDLE.
  - Back-to-back: a new req_valid is first sampled in the IDLE cycle after RESP. The minimum request spacing is therefore LATENCY+1 cycles.
- Outputs outside RESP: resp_addr_ok, resp_data_ok and resp_err are 0; resp_data holds its last value.
- proto_err: set in WAIT when req_valid=1 and req_addr != addr_q. The latched addr_q is still used. Cleared only by rst.
- Preload write:
  - mem[wr_idx] <= wr_data on any edge with wr_en=1, in any state.
  - A write at the same edge as the array read entering RESP is not visible; the old data is returned.

Test Plan:
- LATENCY=2, mem[0]=32'h0000_0013, req 0x8000_0000 asserted at cycle 0 -> resp_addr_ok=resp_data_ok=1 and resp_data=0x13 only in cycle 2; resp_count=1 afterwards.
- Stall: same request with stall=1 in cycles 1 and 2 -> response in cycle 4, single-cycle pulse.
- Errors:
  - req 0x8000_0002 -> response with resp_err=1, resp_data=0.
  - req 0x7FFF_FFFC -> resp_err=1.
  - req BASE+4*DEPTH -> resp_err=1.
- Abort/reset: req_valid dropped in cycle 1 -> no response, state IDLE. Separately, rst pulsed in WAIT -> all outputs 0, no later response.
- Protocol/preload:
  - req_addr changed 0x8000_0004->0x8000_0008 during WAIT -> proto_err=1 and sticky; data returned for 0x8000_0004.
  - wr_en to idx 1 at the RESP entry edge -> old word returned; the next request to idx 1 returns the new word.
- Sequential fetch of 0x8000_0000..0x8000_000C with an initiator that holds valid until the response -> four responses spaced 3 cycles apart (LATENCY=2); resp_count=4; resp_count wraps 0xFFFF_FFFF->0 when preset via force.
